wb_arbiter: RTL

Dual-issue writeback arbiter driving both write ports of the dual-ported register file. Accepts one result per cycle from each ALU pipe (A, B) and variable-latency results from a long-latency unit (mul/div, load) over a valid/ready handshake. Buffers long-latency results in a small FIFO, slots them into idle write ports, resolves same-register conflicts in program order, and exports a pending-write bitmap for the issue stage's hazard stall.

---
 rtl/wb_arbiter_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 112 +++++++++++
 rtl/wb_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module : wb_arbiter_pkg
// Brief  : Shared widths, constants and request type for the writeback arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 1 << REG_AW;

    localparam logic [REG_AW-1:0] R0 = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic addr_hit(input wb_req_t req, input logic [REG_AW-1:0] addr);
        return req.valid && (req.addr == addr);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module : wb_fifo
// Brief  : Long-latency result FIFO with per-entry kill-by-address and pending decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              push_live_i,
    input  logic [REG_AW-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              kill_a_i,
    input  logic [REG_AW-1:0] kill_addr_a_i,
    input  logic              kill_b_i,
    input  logic [REG_AW-1:0] kill_addr_b_i,
    output logic              empty_o,
    output logic              ready_o,
    output logic              head_live_o,
    output logic [REG_AW-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [NREGS-1:0]  pending_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  live_q, live_d;
    logic [REG_AW-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    assign empty_o     = (count_q == '0);
    assign ready_o     = (count_q < CNT_W'(DEPTH));
    assign head_live_o = live_q[rd_ptr_q];
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    // Push overrides kill/pop on the same slot: a freshly written entry carries its own liveness.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            always_comb begin
                live_d[i] = live_q[i];
                if ((kill_a_i && addr_q[i] == kill_addr_a_i) ||
                    (kill_b_i && addr_q[i] == kill_addr_b_i)) begin
                    live_d[i] = 1'b0;
                end
                if (pop_i && rd_ptr_q == PTR_W'(i)) begin
                    live_d[i] = 1'b0;
                end
                if (push_i && wr_ptr_q == PTR_W'(i)) begin
                    live_d[i] = push_live_i;
                end
            end
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            live_q  <= live_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pending_o[addr_q[i]] = 1'b1;
            end
        end
        pending_o[0] = 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module : wb_arbiter
// Brief  : Dual-port writeback arbiter for pipes A/B plus a buffered long-latency unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pa_valid_i,
    input  logic [REG_AW-1:0] pa_addr_i,
    input  logic [DATA_W-1:0] pa_data_i,
    input  logic              pb_valid_i,
    input  logic [REG_AW-1:0] pb_addr_i,
    input  logic [DATA_W-1:0] pb_data_i,
    input  logic              ll_valid_i,
    input  logic [REG_AW-1:0] ll_addr_i,
    input  logic [DATA_W-1:0] ll_data_i,
    output logic              ll_ready_o,
    output logic              wr_en_a_o,
    output logic [REG_AW-1:0] wr_addr_a_o,
    output logic [DATA_W-1:0] wr_data_a_o,
    output logic              wr_en_b_o,
    output logic [REG_AW-1:0] wr_addr_b_o,
    output logic [DATA_W-1:0] wr_data_b_o,
    output logic [NREGS-1:0]  pending_o,
    output logic [7:0]        kill_cnt_o
);

    wb_req_t           pa_acc, pb_acc;
    wb_req_t           port_a_d, port_a_q, port_b_d, port_b_q;
    logic              issue_a, head_live, pop_dead, pop_live, ll_push, ll_live;
    logic              fifo_empty, fifo_head_live;
    logic [REG_AW-1:0] fifo_head_addr;
    logic [DATA_W-1:0] fifo_head_data;
    logic [7:0]        kill_cnt_q, kill_cnt_d;

    // A head matching a same-cycle pipe write is treated as dead now, so both
    // ports never target one register in the same cycle.
    always_comb begin
        pa_acc    = '{valid: pa_valid_i && (pa_addr_i != R0), addr: pa_addr_i, data: pa_data_i};
        pb_acc    = '{valid: pb_valid_i && (pb_addr_i != R0), addr: pb_addr_i, data: pb_data_i};
        issue_a   = pa_acc.valid && !addr_hit(pb_acc, pa_acc.addr);
        head_live = fifo_head_live && !addr_hit(pa_acc, fifo_head_addr)
                                   && !addr_hit(pb_acc, fifo_head_addr);
        pop_dead  = !fifo_empty && !head_live;
        pop_live  = !fifo_empty && head_live && (!issue_a || !pb_acc.valid);
        ll_push   = ll_valid_i && ll_ready_o;
        ll_live   = (ll_addr_i != R0) && !addr_hit(pa_acc, ll_addr_i)
                                      && !addr_hit(pb_acc, ll_addr_i);

        port_a_d = '0;
        port_b_d = '0;
        if (issue_a) begin
            port_a_d = pa_acc;
        end else if (pop_live) begin
            port_a_d = '{valid: 1'b1, addr: fifo_head_addr, data: fifo_head_data};
        end
        if (pb_acc.valid) begin
            port_b_d = pb_acc;
        end else if (pop_live && issue_a) begin
            port_b_d = '{valid: 1'b1, addr: fifo_head_addr, data: fifo_head_data};
        end

        kill_cnt_d = kill_cnt_q;
        if (pop_dead && kill_cnt_q != 8'hFF) begin
            kill_cnt_d = kill_cnt_q + 8'd1;
        end
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (ll_push),
        .push_live_i   (ll_live),
        .push_addr_i   (ll_addr_i),
        .push_data_i   (ll_data_i),
        .pop_i         (pop_dead || pop_live),
        .kill_a_i      (pa_acc.valid),
        .kill_addr_a_i (pa_acc.addr),
        .kill_b_i      (pb_acc.valid),
        .kill_addr_b_i (pb_acc.addr),
        .empty_o       (fifo_empty),
        .ready_o       (ll_ready_o),
        .head_live_o   (fifo_head_live),
        .head_addr_o   (fifo_head_addr),
        .head_data_o   (fifo_head_data),
        .pending_o     (pending_o)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_a_q   <= '0;
            port_b_q   <= '0;
            kill_cnt_q <= '0;
        end else begin
            port_a_q   <= port_a_d;
            port_b_q   <= port_b_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    assign wr_en_a_o   = port_a_q.valid;
    assign wr_addr_a_o = port_a_q.addr;
    assign wr_data_a_o = port_a_q.data;
    assign wr_en_b_o   = port_b_q.valid;
    assign wr_addr_b_o = port_b_q.addr;
    assign wr_data_b_o = port_b_q.data;
    assign kill_cnt_o  = kill_cnt_q;

endmodule

`default_nettype wire
